pdp_unit1d_win_arb: RTL
=======================

PDP_UNIT1D_WIN_ARB -- requirements
Module: pdp_unit1d_win_arb

Interface
REQ-001 SHALL have parameter PD_W, default 185, payload width per beat.
REQ-002 SHALL have parameter CNT_W, default 3, width of the window-length config and beat counter.
REQ-003 SHALL have port nvdla_core_clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_win_len  input  CNT_W  beats per pooling window minus 1 (0 = 1 beat, 7 = 8 beats).
REQ-006 SHALL have ports req0_pd/req1_pd  input  PD_W  requester payload.
REQ-007 SHALL have ports req0_vld/req1_vld  input  1  requester valid.
REQ-008 SHALL have ports req0_rdy/req1_rdy  output  1  requester ready.
REQ-009 SHALL have port out_pd  output  PD_W  registered payload.
REQ-010 SHALL have port out_vld  output  1  registered valid; out_rdy  input  1  downstream ready.
REQ-011 SHALL have port out_last  output  1  set with the final beat of a window; out_src  output  1  owning requester of the current out beat.
REQ-012 SHALL have port arb_busy  output  1  high while a window lock is held (state BUSY0/BUSY1).

Function
REQ-013 SHALL compute stg_rdy = out_rdy OR NOT out_vld; a beat is accepted when the granted reqN_vld and reqN_rdy are both high.
REQ-014 SHALL use states IDLE, BUSY0, BUSY1.
REQ-015 In IDLE, SHALL grant combinationally: one valid requester wins; with both valid, the requester not equal to last_owner wins.
REQ-016 SHALL drive reqN_rdy = stg_rdy AND grant(N); the non-granted requester's rdy SHALL be 0.
REQ-017 On an IDLE accept, SHALL latch cfg_win_len into win_len_q and set beat_cnt to 1; go to BUSYn if cfg_win_len != 0, else stay IDLE with the beat marked last.
REQ-018 In BUSYn, SHALL grant only requester n; the other requester SHALL be blocked even if valid and even during bubbles on requester n.
REQ-019 In BUSYn, each accept SHALL increment beat_cnt; the accept with beat_cnt == win_len_q SHALL be marked last, return to IDLE, and set last_owner = n.
REQ-020 Changes to cfg_win_len mid-window SHALL be ignored until the next window start.
REQ-021 On accept, SHALL load out_pd, out_last and out_src; otherwise these hold their value.
REQ-022 SHALL set next out_vld = accept when stg_rdy, else hold 1; latency is 1 cycle, and full throughput is 1 beat/cycle under out_rdy = 1.
REQ-023 While out_vld = 1 and out_rdy = 0, out_pd, out_last and out_src SHALL be stable.
REQ-024 SHALL drive arb_busy = (state != IDLE).

Reset
REQ-025 On nvdla_core_rstn low, SHALL asynchronously set out_vld = 0, state = IDLE, beat_cnt = 0, win_len_q = 0, last_owner = 1 (req0 wins the first tie), out_last = 0, out_src = 0.
REQ-026 SHALL leave out_pd without reset.
REQ-027 Reset mid-window SHALL abandon the window; after release, arbitration SHALL start fresh from IDLE.

Structure
REQ-028 SHALL place the state encoding (IDLE/BUSY0/BUSY1) and the PD_W/CNT_W defaults in shared package pdp_unit1d_pkg.
REQ-029 SHALL implement the output register as a sub-module pdp_vld_rdy_stage (PD_W+2 wide, valid/ready, rdy_in = rdy_out OR NOT vld_out).

Verification
REQ-030 Reset with both valid, cfg_win_len = 3, out_rdy = 1: the first 4 out beats SHALL have out_src = 0, beat 4 with out_last = 1, then 4 beats with out_src = 1.
REQ-031 cfg_win_len = 0, both valid, out_rdy = 1: out_src SHALL alternate 0,1,0,1 with out_last = 1 every beat.
REQ-032 BUSY0 with req0_vld low for 3 cycles and req1_vld high: req1_rdy SHALL stay 0 and arb_busy SHALL stay 1; the window SHALL resume when req0 returns.
REQ-033 out_rdy held 0 for 5 cycles mid-window: out_pd SHALL be stable, req0_rdy = 0, and no beats SHALL be lost or duplicated (scoreboard).
REQ-034 cfg_win_len changed from 3 to 1 after beat 2: the current window SHALL still be 4 beats and the next window 2 beats.
REQ-035 Reset asserted in BUSY1 after 2 beats: out_vld = 0 and arb_busy = 0 immediately; after release, with both valid, req0 SHALL be granted first.

Source files
------------

// File: rtl/pdp_unit1d_pkg.sv
// Shared definitions for the PDP 1D pooling window arbiter.
// Purpose : window-arbiter state encoding and default widths.
// Contents: PD_W_DEF  - default payload width per beat
//           CNT_W_DEF - default width of the window-length config / beat counter
//           arb_state_e - arbiter states (IDLE, BUSY0, BUSY1)
package pdp_unit1d_pkg;

  localparam int PD_W_DEF  = 185;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pdp_vld_rdy_stage.sv
// Single-entry valid/ready register slice.
// Purpose : registers a W-bit beat with full throughput; accepts a new beat
//           whenever the slot is empty or is being drained this cycle.
// Ports   : nvdla_core_clk  - clock
//           nvdla_core_rstn - asynchronous active-low reset
//           i_vld/o_rdy/i_dat - upstream side (o_rdy = i_rdy | ~o_vld)
//           o_vld/i_rdy/o_dat - downstream side
// The low RST_W data bits are reset to 0; the upper bits carry payload only
// and are deliberately left without reset.
module pdp_vld_rdy_stage #(
  parameter int W     = 187,
  parameter int RST_W = 2
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);

  logic               r_vld;
  logic [RST_W-1:0]   r_dat_lo;
  logic [W-1:RST_W]   r_dat_hi;
  logic               w_load;

  assign o_rdy  = i_rdy | ~r_vld;
  assign w_load = i_vld & o_rdy;

  // Valid and the reset-carrying side-band bits; valid only changes when the
  // slot can move, so a stalled beat keeps valid high.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_vld    <= 1'b0;
      r_dat_lo <= '0;
    end else begin
      if (o_rdy) begin
        r_vld <= i_vld;
      end
      if (w_load) begin
        r_dat_lo <= i_dat[RST_W-1:0];
      end
    end
  end

  // Payload bits: no reset needed, they are qualified by r_vld.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_load) begin
      r_dat_hi <= i_dat[W-1:RST_W];
    end
  end

  assign o_vld = r_vld;
  assign o_dat = {r_dat_hi, r_dat_lo};

endmodule

// File: rtl/pdp_unit1d_win_arb.sv
// Two-requester window arbiter for PDP 1D pooling.
// Purpose : grants one requester for a whole pooling window of
//           (cfg_win_len + 1) beats, alternating owners on ties between
//           windows, and registers the chosen beat into a valid/ready slice.
// Ports   : nvdla_core_clk, nvdla_core_rstn (async active-low)
//           cfg_win_len          - beats per window minus 1
//           reqN_pd/vld/rdy      - requester N handshake (N = 0,1)
//           out_pd/vld/rdy       - registered output handshake
//           out_last             - final beat of a window
//           out_src              - requester that supplied the out beat
//           arb_busy             - a window lock is held
module pdp_unit1d_win_arb
  import pdp_unit1d_pkg::*;
#(
  parameter int PD_W  = PD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [CNT_W-1:0] cfg_win_len,
  input  logic [PD_W-1:0]  req0_pd,
  input  logic             req0_vld,
  output logic             req0_rdy,
  input  logic [PD_W-1:0]  req1_pd,
  input  logic             req1_vld,
  output logic             req1_rdy,
  output logic [PD_W-1:0]  out_pd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic             out_src,
  output logic             arb_busy
);

  arb_state_e       r_state;
  logic             r_last_owner;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_win_len;
  logic             r_busy;

  logic             w_stg_rdy;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic             w_src;
  logic             w_last;
  logic [PD_W-1:0]  w_pd;
  logic [PD_W+1:0]  w_stg_dat;

  // Grant: in IDLE a lone requester wins and a tie goes to the requester that
  // did not own the previous window; inside a window only the owner is granted,
  // even while it bubbles.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_gnt0 = req0_vld & (~req1_vld | r_last_owner);
        w_gnt1 = req1_vld & (~req0_vld | ~r_last_owner);
      end
      BUSY0:   w_gnt0 = 1'b1;
      BUSY1:   w_gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_rdy = w_stg_rdy & w_gnt0;
  assign req1_rdy = w_stg_rdy & w_gnt1;
  assign w_acc0   = req0_vld & req0_rdy;
  assign w_acc1   = req1_vld & req1_rdy;
  assign w_acc    = w_acc0 | w_acc1;
  assign w_src    = w_acc1;
  assign w_pd     = w_acc1 ? req1_pd : req0_pd;

  // A window-opening beat is last only for single-beat windows; inside a
  // window the beat count reaching the latched length closes it.
  assign w_last = (r_state == IDLE) ? (cfg_win_len == '0) : (r_beat_cnt == r_win_len);

  // Window FSM. cfg_win_len is only sampled when a window opens, so mid-window
  // reconfiguration takes effect from the next window. last_owner is updated
  // on every window close, including single-beat windows, so ties alternate.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_beat_cnt   <= '0;
      r_win_len    <= '0;
      r_last_owner <= 1'b1;
    end else if (w_acc) begin
      if (r_state == IDLE) begin
        r_win_len  <= cfg_win_len;
        r_beat_cnt <= CNT_W'(1);
        if (cfg_win_len != '0) begin
          r_state <= w_src ? BUSY1 : BUSY0;
          r_busy  <= 1'b1;
        end else begin
          r_last_owner <= w_src;
        end
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        if (w_last) begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_last_owner <= w_src;
        end
      end
    end
  end

  assign arb_busy = r_busy;

  pdp_vld_rdy_stage #(
    .W     (PD_W + 2),
    .RST_W (2)
  ) u_out_stage (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .i_vld           (w_acc),
    .o_rdy           (w_stg_rdy),
    .i_dat           ({w_pd, w_last, w_src}),
    .o_vld           (out_vld),
    .i_rdy           (out_rdy),
    .o_dat           (w_stg_dat)
  );

  assign out_pd   = w_stg_dat[PD_W+1:2];
  assign out_last = w_stg_dat[1];
  assign out_src  = w_stg_dat[0];

endmodule
